// File: rtl/fifo_to_axis_master_if.sv
// fifo_to_axis_master_if: FIFO read port plus AXI-Stream master bus for fifo_to_axis_master.
// Optional macro FIFO_TO_AXIS_LAST_EN adds the m_axis_last signal.
interface fifo_to_axis_master_if #(
   parameter int unsigned data_width = 32
);
   logic                  fifo_ren;
   logic [data_width-1:0] fifo_dout;
   logic                  fifo_empty_n;
   logic [data_width-1:0] m_axis_data;
   logic                  m_axis_valid;
   logic                  m_axis_ready;
`ifdef FIFO_TO_AXIS_LAST_EN
   logic                  m_axis_last;
`endif

   // Adapter side: drives the FIFO read enable and the stream.
   modport master (
`ifdef FIFO_TO_AXIS_LAST_EN
      output m_axis_last,
`endif
      output fifo_ren,
      input  fifo_dout,
      input  fifo_empty_n,
      output m_axis_data,
      output m_axis_valid,
      input  m_axis_ready
   );

   // FIFO and stream sink side.
   modport slave (
`ifdef FIFO_TO_AXIS_LAST_EN
      input  m_axis_last,
`endif
      input  fifo_ren,
      output fifo_dout,
      output fifo_empty_n,
      input  m_axis_data,
      input  m_axis_valid,
      output m_axis_ready
   );
endinterface

// File: rtl/fifo_to_axis_master.sv
// fifo_to_axis_master: read-side stage behind a standard-mode (read latency 1) synchronous FIFO.
// A 3-entry buffer reserves a slot whenever a read is issued, so the stream runs one beat per
// cycle and m_axis_ready never reaches fifo_ren combinationally.
// Optional macro FIFO_TO_AXIS_LAST_EN adds m_axis_last, asserted on every pkt_beats-th beat.
// simulation_delay is kept for interface compatibility; the RTL carries no delays.
module fifo_to_axis_master #(
   parameter int unsigned data_width       = 32,
   parameter int unsigned pkt_beats        = 16,
   parameter real         simulation_delay = 1.0
) (
   input logic                   clk,
   input logic                   rst,
   fifo_to_axis_master_if.master bus
);

   // Elaboration-time sanity checks on the configuration.
   if (pkt_beats < 1) begin : g_bad_pkt_beats
      $error("fifo_to_axis_master: pkt_beats must be >= 1");
   end
   if (simulation_delay < 0.0) begin : g_bad_sim_delay
      $error("fifo_to_axis_master: simulation_delay must be non-negative");
   end

   logic [data_width-1:0] mem_q [0:2];
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic [1:0]            wptr_q, rptr_q;
   logic                  ren;
   logic                  valid;
   logic                  pop;

   // Modulo-3 pointer increment: 2 wraps to 0.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Read issue and pop decode; ren only looks at state and empty_n, never at ready.
   always_comb begin
      valid = (occ_q != 2'd0);
      pop   = valid & bus.m_axis_ready;
      // rst gating keeps ren low while the shared FIFO is being cleared.
      ren   = ~rst & bus.fifo_empty_n & ((occ_q + 2'(inflight_q)) < 2'd3);
      occ_d = occ_q + 2'(inflight_q) - 2'(pop);
   end

   assign bus.fifo_ren     = ren;
   assign bus.m_axis_valid = valid;
   assign bus.m_axis_data  = mem_q[rptr_q];

   // Occupancy, in-flight flag and pointers; reset discards buffered and in-flight words.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         wptr_q     <= 2'd0;
         rptr_q     <= 2'd0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= ren;
         if (inflight_q) begin
            wptr_q <= ptr_inc(wptr_q);
         end
         if (pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
      end
   end

   // Capture the FIFO word one cycle after its read was issued.
   always_ff @(posedge clk) begin
      if (!rst && inflight_q) begin
         mem_q[wptr_q] <= bus.fifo_dout;
      end
   end

`ifdef FIFO_TO_AXIS_LAST_EN
   localparam int unsigned cnt_w = (pkt_beats > 1) ? $clog2(pkt_beats) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(pkt_beats - 1);

   logic [cnt_w-1:0] beat_cnt_q;

   // Beat position within the packet; only accepted beats advance it.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
      end else if (pop) begin
         beat_cnt_q <= (beat_cnt_q == last_cnt) ? '0 : beat_cnt_q + 1'b1;
      end
   end

   assign bus.m_axis_last = (beat_cnt_q == last_cnt) & valid;
`endif

endmodule

// File: tb/tb_fifo_to_axis_master.sv
// tb_fifo_to_axis_master: directed and random checks of fifo_to_axis_master against a queue
// model of the upstream FIFO and an in-order scoreboard.
module tb_fifo_to_axis_master;
   localparam int unsigned data_width = 32;
   localparam int unsigned pkt_beats  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_to_axis_master_if #(.data_width(data_width)) bus ();

   fifo_to_axis_master #(
      .data_width       (data_width),
      .pkt_beats        (pkt_beats),
      .simulation_delay (1.0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [data_width-1:0] fq [$];
   logic [data_width-1:0] exp_q [$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   reads   = 0;
   int   pops    = 0;
   int   beat_n  = 0;
   bit   flush_on_rst = 1'b0;
   logic s_ren, s_valid, s_ready, s_rst;
   logic [data_width-1:0] s_data;
   logic prev_stall = 1'b0;
   logic [data_width-1:0] prev_data;
`ifdef FIFO_TO_AXIS_LAST_EN
   logic s_last, prev_last;
   int   lasts = 0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [data_width-1:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
      bus.fifo_empty_n = 1'b1;
   endtask

   // One clock: sample outputs at negedge+1, run invariants and scoreboard, then model the FIFO.
   task automatic cyc();
      #1;
      s_ren   = bus.fifo_ren;
      s_valid = bus.m_axis_valid;
      s_ready = bus.m_axis_ready;
      s_data  = bus.m_axis_data;
      s_rst   = rst;
`ifdef FIFO_TO_AXIS_LAST_EN
      s_last  = bus.m_axis_last;
`endif
      if (!bus.fifo_empty_n) check("ren_while_empty", 32'(s_ren), 32'd0);
      if (s_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(s_valid), 32'd1);
            check("stall_data", s_data, prev_data);
`ifdef FIFO_TO_AXIS_LAST_EN
            check("stall_last", 32'(s_last), 32'(prev_last));
`endif
         end
         if (s_valid && s_ready) begin
            check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("beat_data", s_data, exp_q.pop_front());
`ifdef FIFO_TO_AXIS_LAST_EN
            check("beat_last", 32'(s_last), 32'((beat_n % pkt_beats) == pkt_beats - 1));
            if (s_last) lasts++;
`endif
            beat_n++;
            pops++;
         end
         if (s_ren) begin
            reads++;
            check("outstanding_le3", 32'((reads - pops) <= 3), 32'd1);
         end
         prev_stall = s_valid & ~s_ready;
         prev_data  = s_data;
`ifdef FIFO_TO_AXIS_LAST_EN
         prev_last  = s_last;
`endif
      end
      @(posedge clk);
      #1;
      if (s_rst && flush_on_rst) begin
         fq.delete();
         exp_q.delete();
         reads  = 0;
         pops   = 0;
         beat_n = 0;
      end else if (s_ren && fq.size() != 0) begin
         bus.fifo_dout = fq.pop_front();
      end
      bus.fifo_empty_n = (fq.size() != 0);
      @(negedge clk);
   endtask

   initial begin
      int ren_cnt;
      int p0;
      int cycles;
      int sent;
`ifdef FIFO_TO_AXIS_LAST_EN
      int l0;
`endif
      bus.fifo_dout    = '0;
      bus.fifo_empty_n = 1'b0;
      bus.m_axis_ready = 1'b0;
      @(negedge clk);

      // Reset held with a non-empty FIFO: no reads, no valid.
      for (int i = 0; i < 100; i++) push(32'(i));
      bus.m_axis_ready = 1'b1;
      repeat (3) begin
         cyc();
         check("t1_ren_in_rst", 32'(s_ren), 32'd0);
         check("t1_valid_in_rst", 32'(s_valid), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("t1_ren_after_rst", 32'(bus.fifo_ren), 32'd1);

      // Streaming 0..99 back-to-back, valid two cycles after the first read.
      for (int k = 0; k < 104; k++) begin
         cyc();
         check("t2_ren", 32'(s_ren), 32'(k < 100));
         check("t2_valid", 32'(s_valid), 32'(k >= 2 && k < 102));
         if (k >= 2 && k < 102) check("t2_data", s_data, 32'(k - 2));
      end
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: exactly three reads, head word held, then drained in order.
      bus.m_axis_ready = 1'b0;
      for (int i = 0; i < 10; i++) push(32'(i));
      ren_cnt = 0;
      repeat (8) begin
         cyc();
         ren_cnt += int'(s_ren);
      end
      check("t3_ren_pulses", 32'(ren_cnt), 32'd3);
      check("t3_valid", 32'(s_valid), 32'd1);
      check("t3_data_held", s_data, 32'd0);
      bus.m_axis_ready = 1'b1;
      p0 = pops;
      repeat (20) cyc();
      check("t3_beats", 32'(pops - p0), 32'd10);
      check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // Random writes and random ready over 10k words.
      p0 = pops;
      sent = 0;
      cycles = 0;
      while ((pops - p0) < 10000 && cycles < 60000) begin
         if (sent < 10000 && $urandom_range(0, 9) < 6) begin
            push($urandom);
            sent++;
         end
         bus.m_axis_ready = 1'($urandom_range(0, 1));
         cyc();
         cycles++;
      end
      check("t4_beats", 32'(pops - p0), 32'd10000);
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

      // Packet boundaries over 12 beats with stalls, starting from a fresh reset.
      flush_on_rst = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
`ifdef FIFO_TO_AXIS_LAST_EN
      l0 = lasts;
`endif
      for (int i = 0; i < 12; i++) push(32'(32'h100 + i));
      p0 = pops;
      cycles = 0;
      while ((pops - p0) < 12 && cycles < 500) begin
         bus.m_axis_ready = 1'($urandom_range(0, 1));
         cyc();
         cycles++;
      end
      check("t5_beats", 32'(pops - p0), 32'd12);
`ifdef FIFO_TO_AXIS_LAST_EN
      check("t5_last_count", 32'(lasts - l0), 32'd3);
`endif

      // Reset with a full buffer and a read in flight, then refill.
      bus.m_axis_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(32'(32'h200 + i));
      repeat (3) cyc();
      check("t6_valid_before_rst", 32'(s_valid), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      check("t6_valid_after_rst", 32'(s_valid), 32'd0);
      check("t6_ren_after_rst", 32'(s_ren), 32'd0);
`ifdef FIFO_TO_AXIS_LAST_EN
      check("t6_last_after_rst", 32'(s_last), 32'd0);
      l0 = lasts;
`endif
      bus.m_axis_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(32'(32'h300 + i));
      p0 = pops;
      cycles = 0;
      while ((pops - p0) < 8 && cycles < 100) begin
         cyc();
         cycles++;
      end
      check("t6_beats", 32'(pops - p0), 32'd8);
`ifdef FIFO_TO_AXIS_LAST_EN
      check("t6_last_count", 32'(lasts - l0), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
